// File: rtl/pipeline_register_file_pkg.sv
// Shared types and constants for the register file and its pending-write scoreboard.
package pipeline_register_file_pkg;

  typedef logic [4:0]  register_id_t;
  typedef logic [31:0] int_t;

  localparam int           REGISTER_COUNT = 32;
  localparam register_id_t REGISTER_ZERO  = 5'd0;

  // Register 0 is hardwired: never written, never claimed, never busy.
  function automatic logic is_tracked(input register_id_t id);
    return id != REGISTER_ZERO;
  endfunction

endpackage

// File: rtl/register_scoreboard.sv
// Per-register pending-write counters: decode claims, write-back commits, flush squashes.
module register_scoreboard
  import pipeline_register_file_pkg::*;
#(
  parameter int MAX_PENDING = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  register_id_t claimId,
  input  logic         claimEnabled,
  input  register_id_t commitId,
  input  logic         commitEnabled,
  input  register_id_t readIdA,
  input  register_id_t readIdB,
  output logic         readBusyA,
  output logic         readBusyB,
  output logic         pendingOverflow
);

  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] COUNT_MAX  = CW'(MAX_PENDING);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_ZERO = '0;

  logic [CW-1:0] count [REGISTER_COUNT];
  logic [CW-1:0] count_next [REGISTER_COUNT];
  logic          claim_hit [REGISTER_COUNT];
  logic          commit_hit [REGISTER_COUNT];
  logic          overflow_next;

  always_comb begin
    overflow_next = pendingOverflow;
    for (int r = 0; r < REGISTER_COUNT; r++) begin
      claim_hit[r]  = claimEnabled  && claimId  == register_id_t'(r) && is_tracked(register_id_t'(r));
      commit_hit[r] = commitEnabled && commitId == register_id_t'(r) && is_tracked(register_id_t'(r));
      count_next[r] = count[r];
      if (!is_tracked(register_id_t'(r))) begin
        count_next[r] = COUNT_ZERO;
      end else if (flush) begin
        count_next[r] = COUNT_ZERO;
      end else if (claim_hit[r] && commit_hit[r]) begin
        count_next[r] = count[r];
      end else if (claim_hit[r]) begin
        if (count[r] == COUNT_MAX) begin
          overflow_next = 1'b1;
        end else begin
          count_next[r] = count[r] + COUNT_ONE;
        end
      end else if (commit_hit[r]) begin
        // A commit with nothing pending belongs to a squashed producer.
        if (count[r] != COUNT_ZERO) begin
          count_next[r] = count[r] - COUNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pendingOverflow <= 1'b0;
      for (int r = 0; r < REGISTER_COUNT; r++) begin
        count[r] <= COUNT_ZERO;
      end
    end else begin
      pendingOverflow <= overflow_next;
      for (int r = 0; r < REGISTER_COUNT; r++) begin
        count[r] <= count_next[r];
      end
    end
  end

  // A producer committing now is bypassed, so it no longer counts toward busy.
  function automatic logic busy_lookup(input register_id_t id);
    logic [CW-1:0] c;
    c = count[id];
    if (commitEnabled && commitId == id && c != COUNT_ZERO) begin
      c = c - COUNT_ONE;
    end
    return c != COUNT_ZERO;
  endfunction

  always_comb begin
    readBusyA = busy_lookup(readIdA);
    readBusyB = busy_lookup(readIdB);
  end

endmodule

// File: rtl/pipeline_register_file.sv
// 32-entry register file with write-through bypass on both read ports and a pending-write scoreboard.
module pipeline_register_file
  import pipeline_register_file_pkg::*;
#(
  parameter int MAX_PENDING = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  register_id_t readIdA,
  input  register_id_t readIdB,
  output int_t         readDataA,
  output int_t         readDataB,
  output logic         readBusyA,
  output logic         readBusyB,
  input  register_id_t regWriteId,
  input  logic         regWriteEnabled,
  input  int_t         regDataWrite,
  input  register_id_t claimId,
  input  logic         claimEnabled,
  input  logic         flush,
  output logic         pendingOverflow
);

  int_t regs [REGISTER_COUNT];
  logic write_valid;

  assign write_valid = regWriteEnabled && is_tracked(regWriteId);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < REGISTER_COUNT; r++) begin
        regs[r] <= '0;
      end
    end else if (write_valid) begin
      regs[regWriteId] <= regDataWrite;
    end
  end

  function automatic int_t read_port(input register_id_t id);
    if (!is_tracked(id)) begin
      return '0;
    end else if (regWriteEnabled && regWriteId == id) begin
      return regDataWrite;
    end
    return regs[id];
  endfunction

  always_comb begin
    readDataA = read_port(readIdA);
    readDataB = read_port(readIdB);
  end

  register_scoreboard #(
    .MAX_PENDING (MAX_PENDING)
  ) scoreboard (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .claimId         (claimId),
    .claimEnabled    (claimEnabled),
    .commitId        (regWriteId),
    .commitEnabled   (regWriteEnabled),
    .readIdA         (readIdA),
    .readIdB         (readIdB),
    .readBusyA       (readBusyA),
    .readBusyB       (readBusyB),
    .pendingOverflow (pendingOverflow)
  );

endmodule

// File: tb/tb_pipeline_register_file.sv
// Directed plus randomized bench for pipeline_register_file against a per-register count model.
module tb_pipeline_register_file;
  import pipeline_register_file_pkg::*;

  localparam int MAX_PENDING = 3;

  logic         clock;
  logic         reset;
  register_id_t readIdA, readIdB, regWriteId, claimId;
  int_t         readDataA, readDataB, regDataWrite;
  logic         readBusyA, readBusyB, regWriteEnabled, claimEnabled, flush, pendingOverflow;

  int compared;
  int mismatched;

  int_t model_regs [REGISTER_COUNT];
  int   model_cnt  [REGISTER_COUNT];
  logic model_ovf;

  // {dataA, dataB, busyA, busyB, overflow}
  logic [66:0] exp_q [$];

  pipeline_register_file #(.MAX_PENDING(MAX_PENDING)) dut (
    .clock           (clock),
    .reset           (reset),
    .readIdA         (readIdA),
    .readIdB         (readIdB),
    .readDataA       (readDataA),
    .readDataB       (readDataB),
    .readBusyA       (readBusyA),
    .readBusyB       (readBusyB),
    .regWriteId      (regWriteId),
    .regWriteEnabled (regWriteEnabled),
    .regDataWrite    (regDataWrite),
    .claimId         (claimId),
    .claimEnabled    (claimEnabled),
    .flush           (flush),
    .pendingOverflow (pendingOverflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int_t model_read(input register_id_t id);
    if (id == 0) return '0;
    if (regWriteEnabled && regWriteId == id) return regDataWrite;
    return model_regs[id];
  endfunction

  function automatic logic model_busy(input register_id_t id);
    int c;
    c = model_cnt[id];
    if (regWriteEnabled && regWriteId == id && c > 0) c--;
    return c != 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < REGISTER_COUNT; r++) begin
      model_regs[r] = '0;
      model_cnt[r]  = 0;
    end
    model_ovf = 1'b0;
  endtask

  task automatic model_clock();
    if (reset) begin
      model_reset();
      return;
    end
    if (regWriteEnabled && regWriteId != 0) model_regs[regWriteId] = regDataWrite;
    if (flush) begin
      for (int r = 0; r < REGISTER_COUNT; r++) model_cnt[r] = 0;
    end else if (!(claimEnabled && regWriteEnabled && claimId == regWriteId)) begin
      if (claimEnabled && claimId != 0) begin
        if (model_cnt[claimId] == MAX_PENDING) model_ovf = 1'b1;
        else model_cnt[claimId]++;
      end
      if (regWriteEnabled && regWriteId != 0 && model_cnt[regWriteId] > 0)
        model_cnt[regWriteId]--;
    end
  endtask

  // Check this cycle's combinational outputs at the falling edge, then advance the model.
  task automatic cycle();
    logic [66:0] e;
    @(negedge clock);
    exp_q.push_back({model_read(readIdA), model_read(readIdB),
                     model_busy(readIdA), model_busy(readIdB), model_ovf});
    e = exp_q.pop_front();
    if (!reset) begin
      check("data_a", readDataA, e[66:35]);
      check("data_b", readDataB, e[34:3]);
      check("busy_a", 32'(readBusyA), 32'(e[2]));
      check("busy_b", 32'(readBusyB), 32'(e[1]));
      check("overflow", 32'(pendingOverflow), 32'(e[0]));
    end
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic drive(input register_id_t ra, input register_id_t rb, input logic we,
                       input register_id_t wid, input int_t wd, input logic ce,
                       input register_id_t cid, input logic fl);
    reset = 1'b0;
    readIdA = ra; readIdB = rb;
    regWriteEnabled = we; regWriteId = wid; regDataWrite = wd;
    claimEnabled = ce; claimId = cid; flush = fl;
    #1;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cycle();
    cycle();

    // Reset state: every register on both ports reads 0, not busy.
    for (int i = 0; i < REGISTER_COUNT; i++) begin
      drive(register_id_t'(i), register_id_t'(31 - i), 0, 0, 0, 0, 0, 0);
      check("reset_data", readDataA, 32'h0);
      check("reset_busy", 32'(readBusyA | readBusyB), 32'h0);
      cycle();
    end
    check("reset_overflow", 32'(pendingOverflow), 32'h0);

    // Write-through bypass and r0 hardwiring.
    drive(5, 0, 1, 5, 32'h12345678, 0, 0, 0);
    check("bypass_r5", readDataA, 32'h12345678);
    cycle();
    drive(5, 0, 0, 0, 0, 0, 0, 0);
    check("array_r5", readDataA, 32'h12345678);
    cycle();
    drive(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
    check("r0_write_bypass", readDataA, 32'h0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("r0_after_write", readDataA, 32'h0);
    cycle();

    // Claim r8, busy from next cycle, cleared by commit bypass.
    drive(8, 0, 0, 0, 0, 1, 8, 0);
    check("claim_r8_c0", 32'(readBusyA), 32'h0);
    cycle();
    for (int i = 1; i <= 2; i++) begin
      drive(8, 0, 0, 0, 0, 0, 0, 0);
      check("claim_r8_busy", 32'(readBusyA), 32'h1);
      cycle();
    end
    drive(8, 0, 1, 8, 32'hAB, 0, 0, 0);
    check("commit_r8_busy", 32'(readBusyA), 32'h0);
    check("commit_r8_data", readDataA, 32'hAB);
    cycle();

    // Saturate r9 and drain with one extra commit.
    for (int i = 0; i < 4; i++) begin
      drive(9, 0, 0, 0, 0, 1, 9, 0);
      cycle();
    end
    drive(9, 0, 0, 0, 0, 0, 0, 0);
    check("r9_overflow", 32'(pendingOverflow), 32'h1);
    for (int i = 0; i < 3; i++) begin
      drive(9, 0, 1, 9, int_t'(i), 0, 0, 0);
      cycle();
    end
    drive(9, 0, 0, 0, 0, 0, 0, 0);
    check("r9_drained", 32'(readBusyA), 32'h0);
    drive(9, 0, 1, 9, 32'h99, 0, 0, 0);
    cycle();
    drive(9, 0, 0, 0, 0, 1, 9, 0);
    cycle();
    drive(9, 0, 0, 0, 0, 0, 0, 0);
    check("r9_no_underflow", 32'(readBusyA), 32'h1);
    cycle();
    drive(9, 0, 1, 9, 32'h9, 0, 0, 0);
    check("r9_last_commit", 32'(readBusyA), 32'h0);
    cycle();

    // Claim+commit same cycle, then flush beating a claim.
    drive(10, 0, 0, 0, 0, 1, 10, 0);
    cycle();
    drive(10, 0, 1, 10, 32'hA, 1, 10, 0);
    cycle();
    drive(10, 0, 0, 0, 0, 0, 0, 0);
    check("r10_held", 32'(readBusyA), 32'h1);
    drive(10, 0, 0, 0, 0, 1, 10, 1);
    cycle();
    drive(10, 0, 0, 0, 0, 0, 0, 0);
    check("r10_flushed", 32'(readBusyA), 32'h0);
    cycle();

    // Reset mid-sequence overrides a write and claims.
    drive(3, 0, 0, 0, 0, 1, 3, 0);
    cycle();
    cycle();
    drive(3, 0, 1, 3, 32'hDEADBEEF, 1, 3, 0);
    reset = 1'b1;
    cycle();
    drive(3, 0, 0, 0, 0, 0, 0, 0);
    check("rst_r3_data", readDataA, 32'h0);
    check("rst_r3_busy", 32'(readBusyA), 32'h0);
    check("rst_overflow", 32'(pendingOverflow), 32'h0);
    cycle();

    // Randomized traffic on a narrow id range to create frequent hazards.
    for (int n = 0; n < 600; n++) begin
      drive(register_id_t'($urandom_range(0, 7)), register_id_t'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), register_id_t'($urandom_range(0, 7)), int_t'($urandom),
            1'($urandom_range(0, 1)), register_id_t'($urandom_range(0, 7)),
            ($urandom_range(0, 31) == 0));
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_register_file.md
# pipeline_register_file

General-purpose register file with an integrated pending-write scoreboard, sitting between the decode stage (reader/claimer) and the write-back stage (writer). It accepts the write-back stage's single write port (`regWriteId`, `regWriteEnabled`, `regDataWrite`) and serves two combinational read ports to decode, with same-cycle write-through bypass. Per-register pending counters, incremented when decode issues an instruction with a destination and decremented when write-back commits, give decode a per-operand busy flag for hazard stalls.

## Interface
- `MAX_PENDING`, default 3: maximum outstanding writes tracked per register (EX, MEM, WB in flight); counter width is `$clog2(MAX_PENDING+1)`.
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `readIdA` / `readIdB`  in  register_id_t  decode source operands.
- `readDataA` / `readDataB`  out  int_t  operand values, bypassed.
- `readBusyA` / `readBusyB`  out  1  operand still has an uncommitted producer.
- `regWriteId`  in  register_id_t  write-back destination.
- `regWriteEnabled`  in  1  write-back commit strobe; already gated by bubble in write-back.
- `regDataWrite`  in  int_t  write-back data.
- `claimId`  in  register_id_t  destination of the instruction leaving decode.
- `claimEnabled`  in  1  decode issues a register-writing instruction this cycle.
- `flush`  in  1  pipeline squash; discard all pending claims.
- `pendingOverflow`  out  1  sticky: a claim hit a saturated counter.

## Operation
- Storage: 32 × int_t. Register 0 is never written, always reads 0, never busy, ignores claims and commits.
- Write: on posedge with `regWriteEnabled` and `regWriteId != 0`, `regs[regWriteId] <= regDataWrite`. Unaffected by `flush`.
- Read (per port X): if `readIdX == 0` → 0; else if `regWriteEnabled && regWriteId == readIdX` → `regDataWrite`; else `regs[readIdX]`.
- Scoreboard, per register r ≠ 0, at posedge, priority order:
  - `flush`: count ← 0 (claims and commits this cycle ignored for counting).
  - claim(r) and commit(r) same cycle: count unchanged.
  - claim(r) only: count+1; if count == MAX_PENDING, hold and set `pendingOverflow`.
  - commit(r) only: count−1; if count == 0, hold at 0 (commit of a squashed/untracked producer, no underflow).
- Busy (per port X): `(count[readIdX] − (commit matches readIdX ? 1 : 0)) != 0`, computed without underflow (count 0 → not busy). A producer committing this cycle is bypassed, hence not busy.
- `pendingOverflow` cleared only by reset.

## Timing
- Reset: all registers 0, all counts 0, `pendingOverflow` 0; consequently all read data 0 and all busy 0 in the cycle after reset.
- Reads and busy are zero-latency combinational from ids and current-cycle write/commit inputs.
- Written data visible through array from the next cycle; through bypass in the same cycle.
- Claim affects busy from the next cycle; commit clears busy in the same cycle (bypass) when it retires the last pending write.
- Reset mid-operation overrides write, claim, commit and flush in that cycle.

## Structure
- Shared definitions package: `register_id_t` (5 bit), `int_t` (32 bit), `REGISTER_COUNT = 32`, `REGISTER_ZERO = 0`.
- Sub-module `register_scoreboard` (parameter `MAX_PENDING`): holds the 31 counters, claim/commit/flush logic, overflow flag and two busy lookups; the top holds the array and bypass muxes.

## Test plan
- Reset, then read ids 0..31 on both ports → all data 0, all busy 0, `pendingOverflow` 0.
- Write r5 ← 0x12345678 with `readIdA = 5` same cycle → `readDataA = 0x12345678` that cycle and next; write to r0 ← 0xFFFFFFFF → r0 reads 0.
- Claim r8 at cycle 0 → `readBusyA` (id 8) = 0 at cycle 0, 1 at cycles 1..2; commit r8 = 0xAB at cycle 3 → busy 0 and data 0xAB at cycle 3.
- Claim r9 three times, fourth claim → count holds 3, `pendingOverflow` = 1; three commits → busy 0; further commit → count stays 0.
- Claim and commit r10 same cycle with count 1 → count stays 1, busy stays 1 next cycle; then `flush` with simultaneous claim r10 → count 0, busy 0 next cycle.
- Claim r3 twice, assert reset mid-sequence with a write to r3 → r3 reads 0, busy 0, overflow 0 after reset.
